reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order commit queue downstream of the reservation station and load/store buffer.
- Allocates one entry per dispatched instruction and captures results broadcast on both CDB channels (RS and LSB).
- Retires at most one instruction per cycle: register writeback, store release, or branch resolution.
- On a mispredict at commit it drives the flush (pre_judge low) that clears RS, LSB and the front end.

Parameters:
ADDR_WIDTH, 32, pc width
RoB_WIDTH, 8, index width; RoB_SIZE = 1 << RoB_WIDTH entries
EX_RoB_WIDTH, 9, index plus one "no dependency" bit
NON_DEP, 9'b1_0000_0000, "no dependency" tag value

Ports:
Sys_clk  in  1  clock, rising edge
Sys_rst_n  in  1  asynchronous active-low reset
Sys_rdy  in  1  when low, all state and outputs hold
DPRoB_en  in  1  allocate one entry this cycle
DPRoB_type  in  2  0: register write, 1: branch, 2: store, 3: jalr
DPRoB_rd  in  5  destination register
DPRoB_pc  in  ADDR_WIDTH  instruction pc
DPRoB_pred_jump  in  1  front-end prediction (1 = taken)
DPRoB_Qj, DPRoB_Qk  in  EX_RoB_WIDTH  operand tags being looked up
RoBDP_full  out  1  count == RoB_SIZE
RoBDP_tail  out  RoB_WIDTH  index the next allocation receives
RoBDP_Qj_ready, RoBDP_Qk_ready  out  1  looked-up tag's value is available
RoBDP_Vj, RoBDP_Vk  out  32  looked-up value
CDBRoB_RS_en, CDBRoB_RS_index, CDBRoB_RS_value, CDBRoB_RS_next_pc  in  1/RoB_WIDTH/32/ADDR_WIDTH  RS broadcast
CDBRoB_LSB_en, CDBRoB_LSB_index, CDBRoB_LSB_value  in  1/RoB_WIDTH/32  LSB broadcast
RoBRF_en  out  1  register-file write pulse
RoBRF_rd  out  5  register to write
RoBRF_value  out  32  value to write
RoBRF_index  out  RoB_WIDTH  committing entry's index
RoBLSB_commit_en  out  1  store release pulse
RoBLSB_commit_index  out  RoB_WIDTH  store being released
RoBRS_pre_judge  out  1  0 = flush; also fans out to LSB, regfile and front end
RoBIF_next_pc  out  ADDR_WIDTH  redirect target, valid while pre_judge == 0

Behaviour:
- Per-entry state: busy, ready, type, rd, pc, pred_jump, value, next_pc.
- Queue pointers: head, tail (RoB_WIDTH bits, natural wrap), count (RoB_WIDTH+1 bits).
- Reset (asynchronous, Sys_rst_n low):
  - All busy/ready bits cleared; head = tail = count = 0.
  - RoBRF_en = 0, RoBLSB_commit_en = 0, RoBRS_pre_judge = 1, RoBIF_next_pc = 0, RoBRF_* = 0.
  - A reset asserted mid-operation drops all entries immediately.
- Allocate (DPRoB_en and not full, at the clock edge):
  - entry[tail]: busy = 1, fields latched from DPRoB_*; tail increments.
  - ready = 0 for every type.
  - DPRoB_en while full is ignored; no state changes.
- Writeback:
  - CDBRoB_RS_en: entry[index] ready = 1, value and next_pc latched.
  - CDBRoB_LSB_en: entry[index] ready = 1, value latched. A store is marked ready when the LSB broadcasts that its address/data are resolved.
  - Both channels may fire in the same cycle for different indices; both are captured.
- Operand lookup is combinational:
  - tag == NON_DEP: ready = 1, V = 0.
  - Otherwise ready = entry[tag].ready, or a same-cycle CDB hit on that tag (bypass).
  - V comes from the CDB when it hits, else from the entry. The RS channel wins if both channels hit.
- Commit: evaluated when entry[head] is busy and ready; at most one entry per cycle; outputs are registered and pulse for one cycle.
  - Register write: RoBRF_en = 1 with rd, value, index.
  - Store: RoBLSB_commit_en = 1 with index.
  - Branch: value[0] is the actual direction.
    - Equal to pred_jump: retire only.
    - Different: mispredict. RoBIF_next_pc = next_pc, RoBRS_pre_judge = 0.
  - jalr: RoBRF_en writes pc+4 (the value field); always a mispredict, redirect to next_pc.
  - The entry is freed and head increments.
- Flush:
  - Cycle after a mispredict commit: pre_judge = 0 for exactly one cycle.
  - On that edge all entries, head, tail and count are cleared; RoBRF_en and RoBLSB_commit_en = 0.
  - Any allocation or CDB write presented in that cycle is discarded.
  - pre_judge returns to 1 on the following edge.
- Simultaneous allocate and commit: allowed, count unchanged. Full is evaluated on pre-edge count, so a commit does not admit an allocation in the same cycle.
- Wrap-around: head and tail roll from RoB_SIZE-1 to 0.
- Empty: nothing commits.
- Sys_rdy low: no allocate, capture or commit. Pulse outputs are held at 0.

Optional Feature:
- Macro: RoB_STATS_EN.
- Defined:
  - Adds 32-bit output counters RoBDBG_commit_cnt (all retirements), RoBDBG_branch_cnt (branch + jalr) and RoBDBG_mispredict_cnt.
  - Counters reset to 0, wrap at 2^32, and are not cleared by a flush.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- RoB_WIDTH=3: allocate 8 register-write entries → RoBDP_full = 1; 9th DPRoB_en is ignored; RoBDP_tail = 0 after wrap.
- Allocate idx0 (rd=5) and idx1 (rd=6). RS broadcasts idx1 = 0x22, then idx0 = 0x11.
  - Expected: commits in order, idx0 (RoBRF rd=5, 0x11) then idx1 (rd=6, 0x22), one per cycle.
- DPRoB_Qj = 2 while CDBRoB_LSB writes idx2 = 0xDEAD in the same cycle → RoBDP_Qj_ready = 1, RoBDP_Vj = 0xDEAD.
- Branch pred_jump = 1, RS returns value 0 with next_pc 0x104, three younger entries present.
  - Expected: pre_judge = 0 for one cycle, RoBIF_next_pc = 0x104, count = 0 afterwards, no RoBRF_en from the younger entries.
- Store at head, LSB broadcast received → RoBLSB_commit_en pulses once with its index; RoBRF_en stays 0.
- Drive Sys_rst_n low mid-stream with 4 entries live → outputs drop to reset values immediately; the next allocation returns RoBDP_tail = 0.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, commit and flush bundle of the reorder buffer.
// Stats ports exist only when RoB_STATS_EN is defined.
interface reorder_buffer_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int RoB_WIDTH    = 8,
    parameter int EX_RoB_WIDTH = RoB_WIDTH + 1
);
    logic                    DPRoB_en;
    logic [1:0]              DPRoB_type;
    logic [4:0]              DPRoB_rd;
    logic [ADDR_WIDTH-1:0]   DPRoB_pc;
    logic                    DPRoB_pred_jump;
    logic [EX_RoB_WIDTH-1:0] DPRoB_Qj;
    logic [EX_RoB_WIDTH-1:0] DPRoB_Qk;
    logic                    RoBDP_full;
    logic [RoB_WIDTH-1:0]    RoBDP_tail;
    logic                    RoBDP_Qj_ready;
    logic                    RoBDP_Qk_ready;
    logic [31:0]             RoBDP_Vj;
    logic [31:0]             RoBDP_Vk;
    logic                    CDBRoB_RS_en;
    logic [RoB_WIDTH-1:0]    CDBRoB_RS_index;
    logic [31:0]             CDBRoB_RS_value;
    logic [ADDR_WIDTH-1:0]   CDBRoB_RS_next_pc;
    logic                    CDBRoB_LSB_en;
    logic [RoB_WIDTH-1:0]    CDBRoB_LSB_index;
    logic [31:0]             CDBRoB_LSB_value;
    logic                    RoBRF_en;
    logic [4:0]              RoBRF_rd;
    logic [31:0]             RoBRF_value;
    logic [RoB_WIDTH-1:0]    RoBRF_index;
    logic                    RoBLSB_commit_en;
    logic [RoB_WIDTH-1:0]    RoBLSB_commit_index;
    logic                    RoBRS_pre_judge;
    logic [ADDR_WIDTH-1:0]   RoBIF_next_pc;
`ifdef RoB_STATS_EN
    logic [31:0]             RoBDBG_commit_cnt;
    logic [31:0]             RoBDBG_branch_cnt;
    logic [31:0]             RoBDBG_mispredict_cnt;
`endif

    modport master (
        output DPRoB_en, DPRoB_type, DPRoB_rd, DPRoB_pc, DPRoB_pred_jump, DPRoB_Qj, DPRoB_Qk,
        output CDBRoB_RS_en, CDBRoB_RS_index, CDBRoB_RS_value, CDBRoB_RS_next_pc,
        output CDBRoB_LSB_en, CDBRoB_LSB_index, CDBRoB_LSB_value,
        input  RoBDP_full, RoBDP_tail, RoBDP_Qj_ready, RoBDP_Qk_ready, RoBDP_Vj, RoBDP_Vk,
        input  RoBRF_en, RoBRF_rd, RoBRF_value, RoBRF_index,
        input  RoBLSB_commit_en, RoBLSB_commit_index, RoBRS_pre_judge, RoBIF_next_pc
`ifdef RoB_STATS_EN
        , input RoBDBG_commit_cnt, RoBDBG_branch_cnt, RoBDBG_mispredict_cnt
`endif
    );

    modport slave (
        input  DPRoB_en, DPRoB_type, DPRoB_rd, DPRoB_pc, DPRoB_pred_jump, DPRoB_Qj, DPRoB_Qk,
        input  CDBRoB_RS_en, CDBRoB_RS_index, CDBRoB_RS_value, CDBRoB_RS_next_pc,
        input  CDBRoB_LSB_en, CDBRoB_LSB_index, CDBRoB_LSB_value,
        output RoBDP_full, RoBDP_tail, RoBDP_Qj_ready, RoBDP_Qk_ready, RoBDP_Vj, RoBDP_Vk,
        output RoBRF_en, RoBRF_rd, RoBRF_value, RoBRF_index,
        output RoBLSB_commit_en, RoBLSB_commit_index, RoBRS_pre_judge, RoBIF_next_pc
`ifdef RoB_STATS_EN
        , output RoBDBG_commit_cnt, RoBDBG_branch_cnt, RoBDBG_mispredict_cnt
`endif
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue with RS/LSB result capture and mispredict flush.
// Define RoB_STATS_EN to add retirement/branch/mispredict counters.
module reorder_buffer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int RoB_WIDTH    = 8,
    parameter int EX_RoB_WIDTH = RoB_WIDTH + 1,
    parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}}
) (
    input  logic            Sys_clk,
    input  logic            Sys_rst_n,
    input  logic            Sys_rdy,
    reorder_buffer_if.slave bus
);
    localparam int SIZE = 1 << RoB_WIDTH;
    localparam logic [RoB_WIDTH:0] FULL_CNT = {1'b1, {RoB_WIDTH{1'b0}}};
    localparam logic [1:0] T_REG = 2'd0, T_BR = 2'd1, T_ST = 2'd2, T_JALR = 2'd3;

    logic                  r_busy    [SIZE];
    logic                  r_ready   [SIZE];
    logic [1:0]            r_type    [SIZE];
    logic [4:0]            r_rd      [SIZE];
    logic [ADDR_WIDTH-1:0] r_pc      [SIZE];
    logic                  r_pred    [SIZE];
    logic [31:0]           r_value   [SIZE];
    logic [ADDR_WIDTH-1:0] r_next_pc [SIZE];

    logic [RoB_WIDTH-1:0]  r_head, r_tail;
    logic [RoB_WIDTH:0]    r_count;
    logic                  r_rf_en, r_lsb_en, r_pre_judge;
    logic [4:0]            r_rf_rd;
    logic [31:0]           r_rf_value;
    logic [RoB_WIDTH-1:0]  r_rf_index, r_lsb_index;
    logic [ADDR_WIDTH-1:0] r_if_next_pc;

    logic w_full, w_active, w_alloc, w_rs_wr, w_lsb_wr, w_commit;
    logic w_rf_wr, w_st_rel, w_is_branch, w_mispredict;
    logic [1:0] w_head_type;
    logic [RoB_WIDTH-1:0] w_qj_idx, w_qk_idx;
    logic [32:0] w_qj, w_qk;

    // Tag lookup: RS broadcast beats LSB broadcast, both beat the stored entry.
    function automatic logic [32:0] lookup(
        input logic [EX_RoB_WIDTH-1:0] tag,
        input logic ent_ready, input logic [31:0] ent_value,
        input logic rs_hit, input logic [31:0] rs_value,
        input logic lsb_hit, input logic [31:0] lsb_value);
        logic [32:0] res;
        if (tag == NON_DEP) res = {1'b1, 32'd0};
        else if (rs_hit)    res = {1'b1, rs_value};
        else if (lsb_hit)   res = {1'b1, lsb_value};
        else                res = {ent_ready, ent_value};
        return res;
    endfunction

    // Allocation, capture and commit decode for this cycle.
    always_comb begin
        w_full       = (r_count == FULL_CNT);
        w_active     = Sys_rdy && r_pre_judge;
        w_alloc      = w_active && bus.DPRoB_en && !w_full;
        w_rs_wr      = w_active && bus.CDBRoB_RS_en;
        w_lsb_wr     = w_active && bus.CDBRoB_LSB_en;
        w_commit     = w_active && r_busy[r_head] && r_ready[r_head];
        w_head_type  = r_type[r_head];
        w_rf_wr      = w_commit && ((w_head_type == T_REG) || (w_head_type == T_JALR));
        w_st_rel     = w_commit && (w_head_type == T_ST);
        w_is_branch  = w_commit && ((w_head_type == T_BR) || (w_head_type == T_JALR));
        w_mispredict = w_commit && ((w_head_type == T_JALR) ||
                       ((w_head_type == T_BR) && (r_value[r_head][0] != r_pred[r_head])));
    end

    // Operand lookup with same-cycle CDB bypass.
    always_comb begin
        w_qj_idx = bus.DPRoB_Qj[RoB_WIDTH-1:0];
        w_qk_idx = bus.DPRoB_Qk[RoB_WIDTH-1:0];
        w_qj = lookup(bus.DPRoB_Qj, r_ready[w_qj_idx], r_value[w_qj_idx],
                      w_rs_wr && (bus.CDBRoB_RS_index == w_qj_idx), bus.CDBRoB_RS_value,
                      w_lsb_wr && (bus.CDBRoB_LSB_index == w_qj_idx), bus.CDBRoB_LSB_value);
        w_qk = lookup(bus.DPRoB_Qk, r_ready[w_qk_idx], r_value[w_qk_idx],
                      w_rs_wr && (bus.CDBRoB_RS_index == w_qk_idx), bus.CDBRoB_RS_value,
                      w_lsb_wr && (bus.CDBRoB_LSB_index == w_qk_idx), bus.CDBRoB_LSB_value);
    end

    // Queue control, entry status bits and registered commit outputs.
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_rf_en      <= 1'b0;
            r_lsb_en     <= 1'b0;
            r_pre_judge  <= 1'b1;
            r_rf_rd      <= 5'd0;
            r_rf_value   <= 32'd0;
            r_rf_index   <= '0;
            r_lsb_index  <= '0;
            r_if_next_pc <= '0;
        end else if (!Sys_rdy) begin
            r_rf_en  <= 1'b0;
            r_lsb_en <= 1'b0;
        end else if (!r_pre_judge) begin
            // Flush cycle: drop every entry, ignore this cycle's dispatch and CDB.
            for (int i = 0; i < SIZE; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rf_en     <= 1'b0;
            r_lsb_en    <= 1'b0;
            r_pre_judge <= 1'b1;
        end else begin
            r_rf_en     <= w_rf_wr;
            r_lsb_en    <= w_st_rel;
            r_pre_judge <= !w_mispredict;
            if (w_mispredict) r_if_next_pc <= r_next_pc[r_head];
            if (w_rf_wr) begin
                r_rf_rd    <= r_rd[r_head];
                r_rf_value <= r_value[r_head];
                r_rf_index <= r_head;
            end
            if (w_st_rel) r_lsb_index <= r_head;
            if (w_lsb_wr) r_ready[bus.CDBRoB_LSB_index] <= 1'b1;
            if (w_rs_wr)  r_ready[bus.CDBRoB_RS_index]  <= 1'b1;
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; validity is tracked by busy/ready so no reset is needed.
    always_ff @(posedge Sys_clk) begin
        if (w_lsb_wr) r_value[bus.CDBRoB_LSB_index] <= bus.CDBRoB_LSB_value;
        if (w_rs_wr) begin
            r_value[bus.CDBRoB_RS_index]   <= bus.CDBRoB_RS_value;
            r_next_pc[bus.CDBRoB_RS_index] <= bus.CDBRoB_RS_next_pc;
        end
        if (w_alloc) begin
            r_type[r_tail] <= bus.DPRoB_type;
            r_rd[r_tail]   <= bus.DPRoB_rd;
            r_pc[r_tail]   <= bus.DPRoB_pc;
            r_pred[r_tail] <= bus.DPRoB_pred_jump;
        end
    end

`ifdef RoB_STATS_EN
    logic [31:0] r_commit_cnt, r_branch_cnt, r_mispredict_cnt;

    // Retirement statistics; a flush does not clear them.
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            r_commit_cnt     <= 32'd0;
            r_branch_cnt     <= 32'd0;
            r_mispredict_cnt <= 32'd0;
        end else begin
            if (w_commit)     r_commit_cnt     <= r_commit_cnt + 32'd1;
            if (w_is_branch)  r_branch_cnt     <= r_branch_cnt + 32'd1;
            if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    assign bus.RoBDBG_commit_cnt     = r_commit_cnt;
    assign bus.RoBDBG_branch_cnt     = r_branch_cnt;
    assign bus.RoBDBG_mispredict_cnt = r_mispredict_cnt;
`endif

    assign bus.RoBDP_full          = w_full;
    assign bus.RoBDP_tail          = r_tail;
    assign bus.RoBDP_Qj_ready      = w_qj[32];
    assign bus.RoBDP_Vj            = w_qj[31:0];
    assign bus.RoBDP_Qk_ready      = w_qk[32];
    assign bus.RoBDP_Vk            = w_qk[31:0];
    assign bus.RoBRF_en            = r_rf_en;
    assign bus.RoBRF_rd            = r_rf_rd;
    assign bus.RoBRF_value         = r_rf_value;
    assign bus.RoBRF_index         = r_rf_index;
    assign bus.RoBLSB_commit_en    = r_lsb_en;
    assign bus.RoBLSB_commit_index = r_lsb_index;
    assign bus.RoBRS_pre_judge     = r_pre_judge;
    assign bus.RoBIF_next_pc       = r_if_next_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer with an 8-entry queue (RoB_WIDTH = 3).
module tb_reorder_buffer;
    localparam logic [1:0] EV_RF = 2'd0, EV_ST = 2'd1, EV_FLUSH = 2'd2;
    localparam logic [3:0] NDEP = 4'b1000;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] aux;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   n_vec = 0;
    int   n_miss = 0;
    ev_t  sb_q[$];

    logic [1:0]  m_type  [8];
    logic [4:0]  m_rd    [8];
    logic        m_ready [8];
    logic        m_pred  [8];
    logic [31:0] m_value [8];
    logic [31:0] m_npc   [8];
    logic [2:0]  m_head, m_tail;
    int          m_count;

    always #5 clk = ~clk;

    reorder_buffer_if #(.ADDR_WIDTH(32), .RoB_WIDTH(3), .EX_RoB_WIDTH(4)) bus ();

    reorder_buffer #(.ADDR_WIDTH(32), .RoB_WIDTH(3), .EX_RoB_WIDTH(4), .NON_DEP(NDEP)) dut (
        .Sys_clk   (clk),
        .Sys_rst_n (rst_n),
        .Sys_rdy   (rdy),
        .bus       (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_ready[i] = 1'b0;
        m_head  = 3'd0;
        m_tail  = 3'd0;
        m_count = 0;
    endtask

    // Retire every ready entry at the model head, pushing the expected outputs.
    task automatic sb_drain();
        ev_t e;
        while (m_count > 0 && m_ready[m_head]) begin
            e = '0;
            case (m_type[m_head])
                2'd0: begin
                    e.kind = EV_RF; e.rd = m_rd[m_head]; e.val = m_value[m_head];
                    e.aux = {29'd0, m_head};
                    sb_q.push_back(e);
                end
                2'd1: begin
                    if (m_value[m_head][0] != m_pred[m_head]) begin
                        e.kind = EV_FLUSH; e.aux = m_npc[m_head];
                        sb_q.push_back(e);
                        model_clear();
                        return;
                    end
                end
                2'd2: begin
                    e.kind = EV_ST; e.aux = {29'd0, m_head};
                    sb_q.push_back(e);
                end
                default: begin
                    e.kind = EV_RF; e.rd = m_rd[m_head]; e.val = m_value[m_head];
                    e.aux = {29'd0, m_head};
                    sb_q.push_back(e);
                    e = '0;
                    e.kind = EV_FLUSH; e.aux = m_npc[m_head];
                    sb_q.push_back(e);
                    model_clear();
                    return;
                end
            endcase
            m_ready[m_head] = 1'b0;
            m_head  = m_head + 3'd1;
            m_count = m_count - 1;
        end
    endtask

    task automatic do_alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                            input logic pred);
        bus.DPRoB_en = 1'b1; bus.DPRoB_type = t; bus.DPRoB_rd = rd;
        bus.DPRoB_pc = pc;   bus.DPRoB_pred_jump = pred;
        tick();
        bus.DPRoB_en = 1'b0;
        if (m_count < 8) begin
            m_type[m_tail] = t; m_rd[m_tail] = rd; m_pred[m_tail] = pred;
            m_ready[m_tail] = 1'b0;
            m_tail  = m_tail + 3'd1;
            m_count = m_count + 1;
        end
    endtask

    task automatic cdb(input logic rs_en, input logic [2:0] rs_idx, input logic [31:0] rs_val,
                       input logic [31:0] rs_npc, input logic lsb_en, input logic [2:0] lsb_idx,
                       input logic [31:0] lsb_val);
        bus.CDBRoB_RS_en = rs_en;   bus.CDBRoB_RS_index = rs_idx;
        bus.CDBRoB_RS_value = rs_val; bus.CDBRoB_RS_next_pc = rs_npc;
        bus.CDBRoB_LSB_en = lsb_en; bus.CDBRoB_LSB_index = lsb_idx;
        bus.CDBRoB_LSB_value = lsb_val;
        tick();
        bus.CDBRoB_RS_en = 1'b0;
        bus.CDBRoB_LSB_en = 1'b0;
        if (lsb_en) begin m_ready[lsb_idx] = 1'b1; m_value[lsb_idx] = lsb_val; end
        if (rs_en) begin
            m_ready[rs_idx] = 1'b1; m_value[rs_idx] = rs_val; m_npc[rs_idx] = rs_npc;
        end
        sb_drain();
    endtask

    task automatic compare_event(input ev_t got);
        ev_t want;
        check_val("sb_expected_event", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            want = sb_q.pop_front();
            check_val("ev_kind", 64'(got.kind), 64'(want.kind));
            check_val("ev_rd",   64'(got.rd),   64'(want.rd));
            check_val("ev_val",  64'(got.val),  64'(want.val));
            check_val("ev_aux",  64'(got.aux),  64'(want.aux));
        end
    endtask

    // Commit monitor: every observed pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        ev_t got;
        if (bus.RoBRF_en) begin
            got = '0; got.kind = EV_RF; got.rd = bus.RoBRF_rd; got.val = bus.RoBRF_value;
            got.aux = {29'd0, bus.RoBRF_index};
            compare_event(got);
        end
        if (bus.RoBLSB_commit_en) begin
            got = '0; got.kind = EV_ST; got.aux = {29'd0, bus.RoBLSB_commit_index};
            compare_event(got);
        end
        if (!bus.RoBRS_pre_judge) begin
            got = '0; got.kind = EV_FLUSH; got.aux = bus.RoBIF_next_pc;
            compare_event(got);
        end
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1;
        bus.DPRoB_en = 1'b0; bus.DPRoB_type = 2'd0; bus.DPRoB_rd = 5'd0; bus.DPRoB_pc = 32'd0;
        bus.DPRoB_pred_jump = 1'b0; bus.DPRoB_Qj = NDEP; bus.DPRoB_Qk = NDEP;
        bus.CDBRoB_RS_en = 1'b0; bus.CDBRoB_RS_index = 3'd0; bus.CDBRoB_RS_value = 32'd0;
        bus.CDBRoB_RS_next_pc = 32'd0; bus.CDBRoB_LSB_en = 1'b0; bus.CDBRoB_LSB_index = 3'd0;
        bus.CDBRoB_LSB_value = 32'd0;
        model_clear();
        #12;
        check_val("rst_full",      64'(bus.RoBDP_full),       64'd0);
        check_val("rst_tail",      64'(bus.RoBDP_tail),       64'd0);
        check_val("rst_pre_judge", 64'(bus.RoBRS_pre_judge),  64'd1);
        check_val("rst_rf_en",     64'(bus.RoBRF_en),         64'd0);
        check_val("rst_lsb_en",    64'(bus.RoBLSB_commit_en), 64'd0);
        check_val("rst_next_pc",   64'(bus.RoBIF_next_pc),    64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill to capacity, then try one more.
        for (int i = 0; i < 8; i++) do_alloc(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0);
        check_val("full_after_8", 64'(bus.RoBDP_full), 64'd1);
        check_val("tail_wrap",    64'(bus.RoBDP_tail), 64'(m_tail));
        do_alloc(2'd0, 5'd31, 32'h2000, 1'b0);
        check_val("full_9th_ignored", 64'(bus.RoBDP_full), 64'd1);
        check_val("tail_9th_ignored", 64'(bus.RoBDP_tail), 64'd0);

        // Same-cycle LSB bypass on Qj, NON_DEP and a pending tag on Qk.
        bus.DPRoB_Qj = 4'd2; bus.DPRoB_Qk = NDEP;
        bus.CDBRoB_LSB_en = 1'b1; bus.CDBRoB_LSB_index = 3'd2; bus.CDBRoB_LSB_value = 32'hDEAD;
        #1;
        check_val("qj_bypass_ready", 64'(bus.RoBDP_Qj_ready), 64'd1);
        check_val("qj_bypass_val",   64'(bus.RoBDP_Vj),       64'hDEAD);
        check_val("qk_nondep_ready", 64'(bus.RoBDP_Qk_ready), 64'd1);
        check_val("qk_nondep_val",   64'(bus.RoBDP_Vk),       64'd0);
        bus.DPRoB_Qk = 4'd3;
        #1;
        check_val("qk_pending_ready", 64'(bus.RoBDP_Qk_ready), 64'd0);
        tick();
        bus.CDBRoB_LSB_en = 1'b0;
        m_ready[2] = 1'b1; m_value[2] = 32'hDEAD;
        #1;
        check_val("qj_stored_ready", 64'(bus.RoBDP_Qj_ready), 64'd1);
        check_val("qj_stored_val",   64'(bus.RoBDP_Vj),       64'hDEAD);
        bus.DPRoB_Qj = NDEP; bus.DPRoB_Qk = NDEP;

        // Out-of-order results, including RS and LSB in the same cycle.
        cdb(1'b1, 3'd1, 32'h101, 32'h0, 1'b0, 3'd0, 32'h0);
        cdb(1'b1, 3'd0, 32'h100, 32'h0, 1'b0, 3'd0, 32'h0);
        cdb(1'b1, 3'd3, 32'h103, 32'h0, 1'b1, 3'd4, 32'h104);
        for (int i = 5; i < 8; i++) cdb(1'b1, 3'(i), 32'h100 + 32'(i), 32'h0, 1'b0, 3'd0, 32'h0);
        repeat (10) tick();
        check_val("drained_not_full", 64'(bus.RoBDP_full), 64'd0);

        // In-order commit after reversed broadcast order.
        do_alloc(2'd0, 5'd5, 32'h300, 1'b0);
        do_alloc(2'd0, 5'd6, 32'h304, 1'b0);
        cdb(1'b1, m_tail - 3'd1, 32'h22, 32'h0, 1'b0, 3'd0, 32'h0);
        cdb(1'b1, m_tail - 3'd2, 32'h11, 32'h0, 1'b0, 3'd0, 32'h0);
        repeat (4) tick();

        // Mispredicted branch with three resolved younger entries behind it.
        do_alloc(2'd1, 5'd0, 32'h100, 1'b1);
        for (int i = 0; i < 3; i++) do_alloc(2'd0, 5'(10 + i), 32'h104 + 32'(4 * i), 1'b0);
        for (int i = 1; i < 4; i++) cdb(1'b1, m_head + 3'(i), 32'h50 + 32'(i), 32'h0, 1'b0, 3'd0, 32'h0);
        cdb(1'b1, m_head, 32'h0, 32'h104, 1'b0, 3'd0, 32'h0);
        repeat (5) tick();
        check_val("flush_tail", 64'(bus.RoBDP_tail), 64'd0);
        check_val("flush_full", 64'(bus.RoBDP_full), 64'd0);

        // Register, store, correct branch, jalr.
        do_alloc(2'd0, 5'd7, 32'h180, 1'b0);
        do_alloc(2'd2, 5'd0, 32'h184, 1'b0);
        do_alloc(2'd1, 5'd0, 32'h188, 1'b0);
        do_alloc(2'd3, 5'd1, 32'h200, 1'b0);
        cdb(1'b1, 3'd0, 32'h77, 32'h0, 1'b1, 3'd1, 32'h0);
        cdb(1'b1, 3'd2, 32'h0, 32'h50, 1'b0, 3'd0, 32'h0);
        cdb(1'b1, 3'd3, 32'h204, 32'h300, 1'b0, 3'd0, 32'h0);
        repeat (8) tick();
        check_val("jalr_next_pc", 64'(bus.RoBIF_next_pc), 64'h300);

        // Allocation while not ready is held off.
        rdy = 1'b0;
        bus.DPRoB_en = 1'b1;
        tick();
        bus.DPRoB_en = 1'b0;
        rdy = 1'b1;
        check_val("rdy_low_tail", 64'(bus.RoBDP_tail), 64'd0);

        // Asynchronous reset with live entries.
        for (int i = 0; i < 4; i++) do_alloc(2'd0, 5'(20 + i), 32'h400, 1'b0);
        check_val("live_tail", 64'(bus.RoBDP_tail), 64'd4);
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_val("arst_tail",      64'(bus.RoBDP_tail),      64'd0);
        check_val("arst_next_pc",   64'(bus.RoBIF_next_pc),   64'd0);
        check_val("arst_pre_judge", 64'(bus.RoBRS_pre_judge), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("post_rst_tail", 64'(bus.RoBDP_tail), 64'd0);
        do_alloc(2'd0, 5'd9, 32'h500, 1'b0);
        check_val("post_rst_alloc", 64'(bus.RoBDP_tail), 64'd1);
        repeat (3) tick();
        check_val("sb_leftover", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
